mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: none; all types come from package common.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset  input  1  reset is synchronous and active-low.
REQ-004 ireq  input  ibus_req_t  instruction request from core (valid, addr).
REQ-005 iresp  output  ibus_resp_t  instruction response (addr_ok, data_ok, data).
REQ-006 dreq  input  dbus_req_t  data request from core (valid, addr, size, strobe, data).
REQ-007 dresp  output  dbus_resp_t  data response (addr_ok, data_ok, data).
REQ-008 oreq  output  cbus_req_t  single shared memory request (valid, is_write, size, addr, strobe, data).
REQ-009 oresp  input  cbus_resp_t  shared memory response (ready, last, data).

Function
REQ-010 The FSM SHALL use exactly three states: IDLE, IBUSY, DBUSY.
REQ-011 IDLE, dreq.valid=1 -> latch dreq into the request register; enter DBUSY next cycle.
REQ-012 IDLE, only ireq.valid=1 -> latch {addr, size=MSIZE4, strobe=0, data=0}; enter IBUSY.
REQ-013 Both valid in IDLE: dbus wins unless last_grant=D, in which case ibus wins (alternation when contending); last_grant resets to I.
REQ-014 Grant cycle SHALL assert addr_ok=1 for one cycle to the winner only; loser sees addr_ok=0, data_ok=0.
REQ-015 In IBUSY/DBUSY, oreq.valid=1 and oreq fields SHALL be driven from the latched register, stable until completion, independent of ireq/dreq changes.
REQ-016 oreq.is_write = |strobe of latched request; ibus transactions always is_write=0.
REQ-017 Completion = oresp.ready & oresp.last in a busy state; same cycle, winner's data_ok=1 and data=oresp.data (combinational pass-through); next state IDLE.
REQ-018 data_ok SHALL pulse exactly one cycle per granted request; never asserted in IDLE.
REQ-019 oresp.ready without last SHALL be ignored (stay busy, no data_ok).
REQ-020 Minimum latency: request in IDLE cycle N -> oreq.valid at N+1 -> data_ok at earliest N+1; next grant earliest cycle after completion.
REQ-021 Requester deasserting valid after grant SHALL NOT abort; transaction completes and data_ok still pulses.
REQ-022 oreq.valid=0 and all oreq fields zero in IDLE.
REQ-023 Responses whose oresp.ready arrives in IDLE SHALL be discarded.

Reset
REQ-024 reset=0 at posedge: state<=IDLE, request register<=0, last_grant<=I; all outputs zero from the following cycle.
REQ-025 Reset mid-transaction SHALL abandon it without data_ok; oreq.valid=0 the next cycle.
REQ-026 Reset SHALL override any simultaneous completion or new request.

Structure
REQ-027 cbus_req_t, cbus_resp_t, msize_t (MSIZE1/2/4/8), ibus/dbus types SHALL live in package common.
REQ-028 FSM state enum and last_grant are local to mem_arbiter.
REQ-029 No sub-module; single module with one always_ff block for state/request register and combinational output logic.

Verification
REQ-030 Only ireq addr=0x8000_0000 in IDLE; oresp ready&last 3 cycles later with data 0x0000_0013 -> iresp.addr_ok one cycle, oreq.valid for 3 cycles, iresp.data_ok one cycle with data 0x13.
REQ-031 ireq and dreq (addr 0x8000_1000, strobe 0xFF, data 0xDEAD) together -> dbus first (is_write=1); next contention cycle -> ibus granted (alternation).
REQ-032 dreq read, oresp.ready=1 last=0 for 2 cycles then last=1 -> dresp.data_ok only on last cycle.
REQ-033 Drop dreq.valid one cycle after grant -> oreq fields unchanged, dresp.data_ok still pulses at completion.
REQ-034 reset=0 during DBUSY while oresp.last=1 -> no data_ok, state IDLE, oreq.valid=0 next cycle.
REQ-035 oresp.ready=1 while IDLE -> no data_ok on either side.

Source files
------------

// File: rtl/common_pkg.sv
// ---------------------------------------------------------------------------
// common -- shared bus types for the core-to-memory path.
//
// Contents:
//   msize_t      transfer size (MSIZE1/2/4/8 bytes)
//   ibus_req_t   instruction fetch request  {valid, addr}
//   ibus_resp_t  instruction fetch response {addr_ok, data_ok, data}
//   dbus_req_t   data request  {valid, addr, size, strobe, data}
//   dbus_resp_t  data response {addr_ok, data_ok, data}
//   cbus_req_t   shared memory request  {valid, is_write, size, addr, strobe, data}
//   cbus_resp_t  shared memory response {ready, last, data}
// ---------------------------------------------------------------------------
package common;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int STRB_W = DATA_W / 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [STRB_W-1:0] strobe_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } ibus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } ibus_resp_t;

    typedef struct packed {
        logic    valid;
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

    typedef struct packed {
        logic    valid;
        logic    is_write;
        msize_t  size;
        addr_t   addr;
        strobe_t strobe;
        word_t   data;
    } cbus_req_t;

    typedef struct packed {
        logic  ready;
        logic  last;
        word_t data;
    } cbus_resp_t;

endpackage : common

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter -- funnels the instruction bus and the data bus onto one shared
// memory bus, one transaction at a time.
//
// Ports:
//   clk    sole clock, all state changes on its rising edge
//   reset  synchronous, active-low
//   ireq   instruction request in         iresp  instruction response out
//   dreq   data request in                dresp  data response out
//   oreq   shared memory request out      oresp  shared memory response in
//
// A request seen in IDLE is granted in that same cycle (addr_ok) and copied
// into a request register; the shared bus is then driven only from that copy
// until a response beat with both ready and last arrives, which is passed
// straight back to the winner as data_ok/data. Under contention the data bus
// wins unless it won the previous grant, so the two sides alternate.
// ---------------------------------------------------------------------------
module mem_arbiter
    import common::*;
(
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp
);

    typedef enum logic [1:0] {
        IDLE,
        IBUSY,
        DBUSY
    } state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } grant_t;

    state_t    state;
    grant_t    last_grant;
    cbus_req_t req_q;

    logic grant_d;
    logic grant_i;
    logic done;

    // Winner selection; only acted upon while IDLE.
    assign grant_d = dreq.valid && (!ireq.valid || (last_grant == GRANT_I));
    assign grant_i = ireq.valid && !grant_d;

    // A beat without last is an intermediate beat and is ignored.
    assign done = (state != IDLE) && oresp.ready && oresp.last;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            req_q      <= '0;
            last_grant <= GRANT_I;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state      <= DBUSY;
                        last_grant <= GRANT_D;
                        req_q      <= '{valid:    1'b1,
                                        is_write: |dreq.strobe,
                                        size:     dreq.size,
                                        addr:     dreq.addr,
                                        strobe:   dreq.strobe,
                                        data:     dreq.data};
                    end else if (grant_i) begin
                        state      <= IBUSY;
                        last_grant <= GRANT_I;
                        req_q      <= '{valid:    1'b1,
                                        is_write: 1'b0,
                                        size:     MSIZE4,
                                        addr:     ireq.addr,
                                        strobe:   '0,
                                        data:     '0};
                    end
                end
                IBUSY, DBUSY: begin
                    if (done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are held at zero while reset is asserted so that a completion
    // or a new request in the reset cycle is never reported.
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        iresp = '0;
        dresp = '0;
        oreq  = '0;
        if (reset) begin
            case (state)
                IDLE: begin
                    iresp.addr_ok = grant_i;
                    dresp.addr_ok = grant_d;
                end
                IBUSY: begin
                    oreq = req_q;
                    if (done) begin
                        iresp.data_ok = 1'b1;
                        iresp.data    = oresp.data;
                    end
                end
                DBUSY: begin
                    oreq = req_q;
                    if (done) begin
                        dresp.data_ok = 1'b1;
                        dresp.data    = oresp.data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : mem_arbiter
